pipelined_addsub: RTL and testbench

//  Parametrised, skewed-carry pipelined adder/subtractor with valid/ready flow control,

---
 rtl/pipelined_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_addsub.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Skewed-carry pipelined adder/subtractor. Each stage adds one CW-bit chunk, so the carry
// chain per clock is only CW bits long. The pipeline freezes as a whole on back-pressure.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is low only while a result is held waiting for out_ready.

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic [TAG_W-1:0] tag_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];

  logic             v_src   [STAGES];
  logic [TAG_W-1:0] t_src   [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] r_src   [STAGES];
  logic             c_src   [STAGES];
  logic [CW:0]      chunk   [STAGES];

  logic stall;
  logic advance;

  assign stall    = valid_q[L] && !out_ready;
  assign in_ready = !stall;
  assign advance  = !stall || flush;

  // Stage 0 takes the raw operands (B already inverted for subtract); later stages
  // take the previous stage's registers.
  always_comb begin : stage_inputs
    v_src[0] = in_valid;
    t_src[0] = in_tag;
    a_src[0] = in_a;
    b_src[0] = in_sub ? ~in_b : in_b;
    r_src[0] = '0;
    c_src[0] = in_sub;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = valid_q[k-1];
      t_src[k] = tag_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      r_src[k] = res_q[k-1];
      c_src[k] = carry_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_src[k]};
    end
  end

  always_comb begin : next_state
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      tag_d[k]   = tag_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      res_d[k]   = res_q[k];
      carry_d[k] = carry_q[k];
    end
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_d[k]              = v_src[k] && !flush;
        tag_d[k]                = t_src[k];
        a_d[k]                  = a_src[k];
        b_d[k]                  = b_src[k];
        res_d[k]                = r_src[k];
        res_d[k][k*CW +: CW]    = chunk[k][CW-1:0];
        carry_d[k]              = chunk[k][CW];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        res_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        tag_q[k]   <= tag_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        res_q[k]   <= res_d[k];
        carry_q[k] <= carry_d[k];
      end
    end
  end

  assign out_valid = valid_q[L];
  assign out_sum   = {carry_q[L], res_q[L]};
  assign out_tag   = tag_q[L];
  // Signed overflow: operands agree in sign but the result does not.
  assign out_ovf   = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) &&
                     (res_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 32-bit/4-stage main build checked against an arithmetic
// model, plus three 8-bit builds (1, 2 and 8 stages) for latency and boundary sums.
module tb_pipelined_addsub;

  localparam int EW = 38;  // {tag, ovf, carry, sum}

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] out_sum;
  logic        out_ovf;
  logic [3:0]  out_tag;

  logic        rand_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n_results = 0;
  logic [EW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out;

  // 8-bit sweep builds share one set of inputs
  logic [7:0] s_a, s_b;
  logic       s_sub, s_valid;
  logic       s_ready = 1'b1;
  logic       s_flush = 1'b0;
  logic [1:0] s_tag = 2'b10;
  logic       r1, r2, r8, v1, v2, v8, f1, f2, f8;
  logic [8:0] o1, o2, o8;
  logic [1:0] g1, g2, g8;

  always #5 clock = ~clock;

  pipelined_addsub #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .out_tag(out_tag));

  pipelined_addsub #(.WIDTH(8), .STAGES(1), .TAG_W(2)) dut8_1 (
    .clock(clock), .reset(reset), .flush(s_flush), .in_valid(s_valid), .in_ready(r1),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .in_tag(s_tag), .out_valid(v1),
    .out_ready(s_ready), .out_sum(o1), .out_ovf(f1), .out_tag(g1));

  pipelined_addsub #(.WIDTH(8), .STAGES(2), .TAG_W(2)) dut8_2 (
    .clock(clock), .reset(reset), .flush(s_flush), .in_valid(s_valid), .in_ready(r2),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .in_tag(s_tag), .out_valid(v2),
    .out_ready(s_ready), .out_sum(o2), .out_ovf(f2), .out_tag(g2));

  pipelined_addsub #(.WIDTH(8), .STAGES(8), .TAG_W(2)) dut8_8 (
    .clock(clock), .reset(reset), .flush(s_flush), .in_valid(s_valid), .in_ready(r8),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .in_tag(s_tag), .out_valid(v8),
    .out_ready(s_ready), .out_sum(o8), .out_ovf(f8), .out_tag(g8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic. Returns {ovf, carry, result}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    longint sa, sb, r;
    logic [32:0] s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      s = {(a >= b), a - b};
      r = sa - sb;
    end else begin
      s = {1'b0, a} + {1'b0, b};
      r = sa + sb;
    end
    return {(r > 64'sd2147483647) || (r < -64'sd2147483648), s};
  endfunction

  always @(posedge clock) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Compare process: looks at the state that the next rising edge will act on.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_tag, out_ovf, out_sum}, prev_out);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else chk("result", {out_tag, out_ovf, out_sum}, exp_q[0]);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_out = {out_tag, out_ovf, out_sum};
      if (flush) exp_q.delete();
      else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n_results++;
        end
        if (in_valid && in_ready) exp_q.push_back({in_tag, model(in_a, in_b, in_sub)});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [3:0] tag);
    logic done;
    done = 1'b0;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      done = in_ready;
      @(posedge clock);
      #1;
    end
    if (!done) chk("send_timeout", done, 1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("drain_timeout", i < 200, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic sweep(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic [8:0] exp_sum);
    int l1, l2, l8;
    logic [8:0] q1, q2, q8;
    logic [2:0] ov;
    l1 = 0; l2 = 0; l8 = 0; q1 = '0; q2 = '0; q8 = '0; ov = '0;
    s_a = a; s_b = b; s_sub = sub; s_valid = 1'b1;
    @(negedge clock);
    chk("sweep_ready", {r1, r2, r8}, 3'b111);
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (v1 && l1 == 0) begin l1 = n; q1 = o1; ov[0] = f1; end
      if (v2 && l2 == 0) begin l2 = n; q2 = o2; ov[1] = f2; end
      if (v8 && l8 == 0) begin l8 = n; q8 = o8; ov[2] = f8; end
    end
    chk("sweep_lat_s1", l1, 1);
    chk("sweep_lat_s2", l2, 2);
    chk("sweep_lat_s8", l8, 8);
    chk("sweep_sum_s1", q1, exp_sum);
    chk("sweep_sum_s2", q2, exp_sum);
    chk("sweep_sum_s8", q8, exp_sum);
    chk("sweep_ovf", ov, 3'b000);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n;
    int n0;
    int cnt;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_tag = '0; s_a = '0; s_b = '0; s_sub = 1'b0; s_valid = 1'b0;
    #12;
    chk("reset_outputs", {out_valid, out_sum, out_ovf, out_tag}, '0);
    chk("reset_sweep_valid", {v1, v2, v8}, 3'b000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_in_ready", in_ready, 1);

    // pin the model with hand-computed values
    chk("model_add", model(32'd3827, 32'd9273, 1'b0), {1'b0, 33'd13100});
    chk("model_ripple", model(32'h0FFFFFFF, 32'hFFFFFFEF, 1'b0), {1'b0, 33'h1_0FFFFFEE});
    chk("model_addovf", model(32'h7FFFFFFF, 32'd1, 1'b0), {1'b1, 33'h0_80000000});
    chk("model_sub_neg", model(32'd5, 32'd7, 1'b1), {1'b0, 33'h0_FFFFFFFE});
    chk("model_subovf", model(32'h80000000, 32'd1, 1'b1), {1'b1, 33'h1_7FFFFFFF});
    chk("model_sub_eq", model(32'h1234, 32'h1234, 1'b1), {1'b0, 33'h1_00000000});

    // single add: latency, value, tag, one-cycle valid
    @(posedge clock);
    #1;
    send(32'd3827, 32'd9273, 1'b0, 4'd3);
    in_valid = 1'b0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    chk("t1_latency", n, 4);
    chk("t1_sum", out_sum, 33'd13100);
    chk("t1_ovf", out_ovf, 0);
    chk("t1_tag", out_tag, 4'd3);
    @(negedge clock);
    chk("t1_one_cycle", out_valid, 0);
    @(posedge clock);
    #1;

    // carry ripple, overflow, subtract corners, back to back
    send(32'h0FFFFFFF, 32'hFFFFFFEF, 1'b0, 4'd1);
    send(32'h7FFFFFFF, 32'd1, 1'b0, 4'd2);
    send(32'd5, 32'd7, 1'b1, 4'd4);
    send(32'h80000000, 32'd1, 1'b1, 4'd5);
    send(32'h1234, 32'h1234, 1'b1, 4'd6);
    in_valid = 1'b0;
    drain();

    // random traffic with random back-pressure
    n0 = n_results;
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;
    chk("t4_count", n_results - n0, 16);
    @(posedge clock);
    #1;

    // flush with three in flight, plus an input offered on the flush edge
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 4'(i));
    flush = 1'b1; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid) cnt++;
    end
    chk("t5_flush_no_output", cnt, 0);
    chk("t5_flush_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    n0 = n_results;
    send(32'd100, 32'd23, 1'b1, 4'd9);
    in_valid = 1'b0;
    drain();
    chk("t5_after_flush", n_results - n0, 1);

    // asynchronous reset with the oldest op already at the output
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'b0, 4'(i + 8));
    in_valid = 1'b0;
    chk("t5_pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("t5_reset_outputs", {out_valid, out_sum, out_ovf, out_tag}, '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n0 = n_results;
    send(32'hFFFFFFFF, 32'd1, 1'b0, 4'd7);
    in_valid = 1'b0;
    drain();
    chk("t5_after_reset", n_results - n0, 1);

    // 8-bit builds with 1, 2 and 8 stages
    sweep(8'hFF, 8'h01, 1'b0, 9'h100);
    sweep(8'h00, 8'h01, 1'b1, 9'h0FF);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
